// File: rtl/rcosc_tick_seq_pkg.sv
// Shared constants for the RC-oscillator tick generator and fabric reset sequencer.
package rcosc_tick_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  localparam int unsigned MS_PER_S   = 1000;
  localparam int unsigned HB_HALF_MS = MS_PER_S / 2;

endpackage

// File: rtl/rcosc_tick_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rcosc_tick_seq.sv
// 1 ms / 1 s tick generator with heartbeat, plus a LOCK-qualified fabric reset
// sequencer (WAIT -> RUN on sustained lock, WAIT -> FAULT on timeout).
module rcosc_tick_seq
  import rcosc_tick_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned HOLD_MS         = 10,
  parameter int unsigned LOCK_TIMEOUT_MS = 100
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LOCK,
  output logic       TICK_1MS,
  output logic       TICK_1S,
  output logic       HEARTBEAT,
  output logic       FAB_RESETN,
  output logic       FAULT,
  output logic [1:0] STATE
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    MS_LAST    = 10'(MS_PER_S - 1);
  localparam logic [9:0]    MS_MID     = 10'(HB_HALF_MS - 1);
  localparam logic [7:0]    HOLD       = 8'(HOLD_MS);
  localparam logic [9:0]    TMO        = 10'(LOCK_TIMEOUT_MS);

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ms_q, ms_d;
  logic          tick_q, tick_d;
  logic          tick1s_q, tick1s_d;
  logic          hb_q, hb_d;
  logic          lock_s;
  state_e        state_q, state_d;
  logic [7:0]    stable_q, stable_d, stable_inc;
  logic [9:0]    tmo_q, tmo_d, tmo_inc;
  logic          fab_q, fault_q;

  sync_2ff u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .d_i    (LOCK),
    .q_o    (lock_s)
  );

  // Tick outputs are registered from next-state values so each flop is high
  // exactly while the prescaler/ms counter hold the qualifying value.
  always_comb begin
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    ms_d     = ms_q;
    if (tick_q) begin
      ms_d = (ms_q == MS_LAST) ? '0 : ms_q + 10'd1;
    end
    tick_d   = (presc_d == PRESC_LAST);
    tick1s_d = tick_d && (ms_d == MS_LAST);
    hb_d     = hb_q ^ (tick_q && ((ms_q == MS_MID) || (ms_q == MS_LAST)));
  end

  always_comb begin
    state_d    = state_q;
    stable_d   = '0;
    tmo_d      = '0;
    stable_inc = (stable_q == '1) ? stable_q : stable_q + 8'd1;
    tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 10'd1;
    unique case (state_q)
      ST_WAIT: begin
        stable_d = lock_s ? (tick_q ? stable_inc : stable_q) : '0;
        tmo_d    = tick_q ? tmo_inc : tmo_q;
        if (lock_s && tick_q && (stable_inc == HOLD)) begin
          state_d = ST_RUN;
        end else if (tick_q && (tmo_inc == TMO)) begin
          state_d = ST_FAULT;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      presc_q  <= '0;
      ms_q     <= '0;
      tick_q   <= 1'b0;
      tick1s_q <= 1'b0;
      hb_q     <= 1'b0;
      state_q  <= ST_WAIT;
      stable_q <= '0;
      tmo_q    <= '0;
      fab_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      tick_q   <= tick_d;
      tick1s_q <= tick1s_d;
      hb_q     <= hb_d;
      state_q  <= state_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      fab_q    <= (state_d == ST_RUN);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign TICK_1MS   = tick_q;
  assign TICK_1S    = tick1s_q;
  assign HEARTBEAT  = hb_q;
  assign FAB_RESETN = fab_q;
  assign FAULT      = fault_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_rcosc_tick_seq.sv
// Bench for rcosc_tick_seq: cycle-indexed reference model plus directed checks.
module tb_rcosc_tick_seq;

  localparam int unsigned TD   = 10;
  localparam int unsigned HOLD = 3;
  localparam int unsigned TMO  = 8;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic       LOCK = 1'b0;
  logic       TICK_1MS, TICK_1S, HEARTBEAT, FAB_RESETN, FAULT;
  logic [1:0] STATE;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state: cycles since reset release, lock delay line, sequencer mode
  int unsigned cyc    = 0;
  bit          lp0    = 1'b0;
  bit          lp1    = 1'b0;
  int unsigned mode   = 0;
  int unsigned held   = 0;
  int unsigned waited = 0;

  rcosc_tick_seq #(
    .TICK_DIV        (TD),
    .HOLD_MS         (HOLD),
    .LOCK_TIMEOUT_MS (TMO)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .LOCK       (LOCK),
    .TICK_1MS   (TICK_1MS),
    .TICK_1S    (TICK_1S),
    .HEARTBEAT  (HEARTBEAT),
    .FAB_RESETN (FAB_RESETN),
    .FAULT      (FAULT),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RESETN) begin : model
    bit tk;
    if (!RESETN) begin
      cyc = 0; lp0 = 1'b0; lp1 = 1'b0; mode = 0; held = 0; waited = 0;
    end else begin
      tk = ((cyc % TD) == TD - 1);
      if (mode == 0) begin
        if (!lp1) held = 0;
        else if (tk) held++;
        if (tk) waited++;
        if (lp1 && tk && held >= HOLD) begin
          mode = 1; held = 0; waited = 0;
        end else if (tk && waited >= TMO) begin
          mode = 2;
        end
      end else if (mode == 1 && !lp1) begin
        mode = 0; held = 0; waited = 0;
      end
      lp1 = lp0;
      lp0 = LOCK;
      cyc++;
    end
  end

  always @(negedge CLK) begin : compare
    logic [6:0] exp_v, act_v;
    exp_v = {((cyc % TD) == TD - 1),
             ((cyc % (TD * 1000)) == TD * 1000 - 1),
             (((cyc / (TD * 500)) % 2) == 1),
             (mode == 1),
             (mode == 2),
             2'(mode)};
    act_v = {TICK_1MS, TICK_1S, HEARTBEAT, FAB_RESETN, FAULT, STATE};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL outputs cyc=%0d got=%b exp=%b (tick,1s,hb,fab,fault,state)",
               cyc, act_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    int unsigned n;
    n = 0;
    while (cyc != t && n < 25000) begin
      @(posedge CLK); #2;
      n++;
    end
    check("wait_cyc", cyc, t);
  endtask

  task automatic do_reset(input logic lock_val);
    @(posedge CLK); #2;
    RESETN = 1'b0;
    LOCK   = lock_val;
    @(negedge CLK);
    check("rst_state", STATE, 0);
    check("rst_fab", FAB_RESETN, 0);
    check("rst_fault", FAULT, 0);
    check("rst_tick", TICK_1MS, 0);
    check("rst_hb", HEARTBEAT, 0);
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    RESETN = 1'b1;
  endtask

  initial begin
    #1 RESETN = 1'b0;

    // LOCK held low: free-running ticks, timeout into sticky FAULT
    do_reset(1'b0);
    wait_cyc(8);     check("tick_8", TICK_1MS, 0);
    wait_cyc(9);     check("tick_9", TICK_1MS, 1);
    wait_cyc(10);    check("tick_10", TICK_1MS, 0);
    wait_cyc(19);    check("tick_19", TICK_1MS, 1);
    wait_cyc(79);    check("fault_79", FAULT, 0); check("state_79", STATE, 0);
    wait_cyc(80);    check("fault_80", FAULT, 1); check("state_80", STATE, 2);
                     check("fab_80", FAB_RESETN, 0);
    wait_cyc(200);   LOCK = 1'b1;
    wait_cyc(4999);  check("hb_4999", HEARTBEAT, 0);
    wait_cyc(5000);  check("hb_5000", HEARTBEAT, 1); check("sticky", STATE, 2);
    wait_cyc(9998);  check("sec_9998", TICK_1S, 0);
    wait_cyc(9999);  check("sec_9999", TICK_1S, 1);
    wait_cyc(10000); check("hb_10000", HEARTBEAT, 0); check("sec_10000", TICK_1S, 0);
    wait_cyc(19999); check("sec_19999", TICK_1S, 1);
    wait_cyc(20000); check("fault_end", FAULT, 1);

    // Reset from FAULT with LOCK high: release after 3 ms of lock
    do_reset(1'b1);
    wait_cyc(29);    check("fab_29", FAB_RESETN, 0);
    wait_cyc(30);    check("fab_30", FAB_RESETN, 1); check("state_30", STATE, 1);
    wait_cyc(100);   LOCK = 1'b0;
    wait_cyc(101);   LOCK = 1'b1;
    wait_cyc(102);   check("fab_102", FAB_RESETN, 1);
    wait_cyc(103);   check("fab_103", FAB_RESETN, 0); check("state_103", STATE, 0);
    wait_cyc(129);   check("fab_129", FAB_RESETN, 0);
    wait_cyc(130);   check("fab_130", FAB_RESETN, 1);
    wait_cyc(150);

    // Reset from RUN: sequencing restarts from zero
    do_reset(1'b1);
    wait_cyc(30);    check("restart_fab", FAB_RESETN, 1);

    // Stable count and timeout hit their limits on the same tick
    do_reset(1'b0);
    wait_cyc(55);    LOCK = 1'b1;
    wait_cyc(79);    check("tie_79", STATE, 0);
    wait_cyc(80);    check("tie_state", STATE, 1); check("tie_fault", FAULT, 0);
    wait_cyc(100);   check("tie_100", FAULT, 0);

    @(posedge CLK); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
